fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle processor: owns the 64-bit program counter, drives the byte address into the combinational instruction memory, and registers each returned 32-bit instruction with its PC toward decode over a valid/ready handshake. It also handles branch/jump redirects, with flush, and out-of-range fetch faults. It sits directly upstream of the instruction memory and between it and the decoder.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from combinational imem, registers instr/PC toward decode.
// Optional FETCH_ALIGN_CHECK_EN turns misaligned redirect targets into a fetch fault instead of truncating them.
module fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'd0,
    parameter logic [63:0] MEM_BYTES = 64'd64
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        out_valid,
    input  logic        out_ready,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_fault,
    output logic [63:0] fault_pc
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    localparam logic [63:0] LAST_PC = MEM_BYTES - 64'd4;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic [63:0] out_pc_q, out_pc_d;
    logic        out_valid_q, out_valid_d;
    logic        fault_q, fault_d;
    logic [63:0] fault_pc_q, fault_pc_d;

    logic advance;
    logic in_range;

    assign advance  = (state_q == FETCH) && (!out_valid_q || out_ready);
    assign in_range = (pc_q <= LAST_PC);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
        fault_d     = fault_q;
        fault_pc_d  = fault_pc_q;

        // Redirect wins over everything, including a same-cycle accept by decode.
        if (redirect_valid) begin
            out_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = HALT;
                fault_d    = 1'b1;
                fault_pc_d = redirect_pc;
            end else begin
                state_d = FETCH;
                pc_d    = redirect_pc;
                fault_d = 1'b0;
            end
`else
            state_d = FETCH;
            pc_d    = redirect_pc & ~64'd3;
            fault_d = 1'b0;
`endif
        end else if (advance) begin
            if (in_range) begin
                out_instr_d = imem_instr;
                out_pc_d    = pc_q;
                out_valid_d = 1'b1;
                pc_d        = pc_q + 64'd4;
            end else begin
                state_d    = HALT;
                fault_d    = 1'b1;
                fault_pc_d = pc_q;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
        end else if ((state_q == HALT) && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            out_instr_q <= 32'd0;
            out_pc_q    <= 64'd0;
            out_valid_q <= 1'b0;
            fault_q     <= 1'b0;
            fault_pc_q  <= 64'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
            fault_q     <= fault_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    assign imem_addr   = pc_q;
    assign out_instr   = out_instr_q;
    assign out_pc      = out_pc_q;
    assign out_valid   = out_valid_q;
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed plan steps followed by a randomized phase,
// all compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

    localparam logic [63:0] RESET_PC  = 64'd0;
    localparam logic [63:0] MEM_BYTES = 64'd64;

    logic        clk;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_valid;
    logic        out_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        fetch_fault;
    logic [63:0] fault_pc;

    int test_count = 0;
    int fail_count = 0;

    logic [7:0] mem [256];

    // Behavioural model of what decode should observe.
    logic [63:0] m_pc;
    logic [31:0] m_instr;
    logic [63:0] m_out_pc;
    bit          m_valid;
    bit          m_halt;
    bit          m_fault;
    logic [63:0] m_fault_pc;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .MEM_BYTES(MEM_BYTES)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_fault   (fetch_fault),
        .fault_pc      (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Big-endian combinational instruction memory (addresses wrap at 256 bytes).
    always_comb begin
        imem_instr = {mem[imem_addr[7:0]], mem[imem_addr[7:0] + 8'd1],
                      mem[imem_addr[7:0] + 8'd2], mem[imem_addr[7:0] + 8'd3]};
    end

    function automatic logic [31:0] word_at(input logic [63:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b], mem[b + 8'd1], mem[b + 8'd2], mem[b + 8'd3]};
    endfunction

    task automatic model_reset();
        m_pc       = RESET_PC;
        m_instr    = 32'd0;
        m_out_pc   = 64'd0;
        m_valid    = 1'b0;
        m_halt     = 1'b0;
        m_fault    = 1'b0;
        m_fault_pc = 64'd0;
    endtask

    task automatic model_step(input bit rdy, input bit rv, input logic [63:0] rpc);
        if (rv) begin
            m_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (rpc % 64'd4 != 64'd0) begin
                m_halt     = 1'b1;
                m_fault    = 1'b1;
                m_fault_pc = rpc;
            end else begin
                m_halt  = 1'b0;
                m_fault = 1'b0;
                m_pc    = rpc;
            end
`else
            m_halt  = 1'b0;
            m_fault = 1'b0;
            m_pc    = rpc - (rpc % 64'd4);
`endif
        end else if (m_halt) begin
            if (rdy) m_valid = 1'b0;
        end else if (!m_valid || rdy) begin
            if (m_pc + 64'd4 <= MEM_BYTES && m_pc < MEM_BYTES) begin
                m_instr  = word_at(m_pc);
                m_out_pc = m_pc;
                m_valid  = 1'b1;
                m_pc     = m_pc + 64'd4;
            end else begin
                m_halt     = 1'b1;
                m_fault    = 1'b1;
                m_fault_pc = m_pc;
                if (rdy) m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_field(input string tag, input logic [63:0] got, input logic [63:0] exp);
        test_count++;
        assert (got === exp)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        check_field({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, m_valid});
        check_field({tag, ".out_pc"}, out_pc, m_out_pc);
        check_field({tag, ".out_instr"}, {32'd0, out_instr}, {32'd0, m_instr});
        check_field({tag, ".imem_addr"}, imem_addr, m_pc);
        check_field({tag, ".fetch_fault"}, {63'd0, fetch_fault}, {63'd0, m_fault});
        check_field({tag, ".fault_pc"}, fault_pc, m_fault_pc);
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, check after the rising edge.
    task automatic applyStimulus(input string tag, input bit rdy, input bit rv, input logic [63:0] rpc);
        @(negedge clk);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        model_step(rdy, rv, rpc);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit rdy;
        bit rv;
        logic [63:0] rpc;
        int guard;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            mem[i]     = 8'h11;
            mem[4 + i] = 8'h22;
            mem[8 + i] = 8'h33;
        end

        reset_n        = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset");
        #2 reset_n = 1'b1;

        applyStimulus("first", 1'b1, 1'b0, 64'd0);
        check_field("first_pc_const", out_pc, 64'd0);
        check_field("first_instr_const", {32'd0, out_instr}, 64'h11111111);
        applyStimulus("seq4", 1'b1, 1'b0, 64'd0);
        check_field("seq4_instr_const", {32'd0, out_instr}, 64'h22222222);

        for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b0, 1'b0, 64'd0);
        check_field("stall_pc_const", out_pc, 64'd4);
        check_field("stall_addr_const", imem_addr, 64'd8);
        applyStimulus("resume", 1'b1, 1'b0, 64'd0);
        check_field("resume_pc_const", out_pc, 64'd8);

        applyStimulus("redir_flush", 1'b1, 1'b1, 64'h20);
        check_field("redir_flush_valid_const", {63'd0, out_valid}, 64'd0);
        applyStimulus("redir_target", 1'b1, 1'b0, 64'd0);
        check_field("redir_target_pc_const", out_pc, 64'h20);

        guard = 0;
        while (!m_halt && guard < 30) begin
            applyStimulus("to_end", 1'b1, 1'b0, 64'd0);
            guard++;
        end
        check_field("end_fault_const", {63'd0, fetch_fault}, 64'd1);
        check_field("end_fault_pc_const", fault_pc, 64'd64);
        for (int i = 0; i < 3; i++) applyStimulus("halted", 1'b1, 1'b0, 64'd0);
        applyStimulus("recover", 1'b1, 1'b1, 64'd0);
        check_field("recover_fault_const", {63'd0, fetch_fault}, 64'd0);
        applyStimulus("recover_first", 1'b1, 1'b0, 64'd0);
        check_field("recover_pc_const", out_pc, 64'd0);

        applyStimulus("misalign", 1'b1, 1'b1, 64'h22);
`ifdef FETCH_ALIGN_CHECK_EN
        check_field("misalign_fault_const", {63'd0, fetch_fault}, 64'd1);
        check_field("misalign_fault_pc_const", fault_pc, 64'h22);
        applyStimulus("misalign_recover", 1'b1, 1'b1, 64'd0);
`else
        applyStimulus("misalign_next", 1'b1, 1'b0, 64'd0);
        check_field("misalign_pc_const", out_pc, 64'h20);
`endif

        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 15) == 0);
            rpc = 64'($urandom_range(0, 80));
            applyStimulus("random", rdy, rv, rpc);
        end

        applyStimulus("pre_reset_redir", 1'b1, 1'b1, 64'd12);
        applyStimulus("pre_reset_fill", 1'b1, 1'b0, 64'd0);
        check_field("pre_reset_valid_const", {63'd0, out_valid}, 64'd1);
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        checkOutput("async_reset");
        check_field("async_reset_addr_const", imem_addr, RESET_PC);
        #1 reset_n = 1'b1;
        applyStimulus("post_reset", 1'b1, 1'b0, 64'd0);
        check_field("post_reset_pc_const", out_pc, RESET_PC);
        applyStimulus("post_reset2", 1'b1, 1'b0, 64'd0);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
